// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner: scans a 4x4 keypad, debounces one key and emits one-cycle command pulses.
// Define KEYPAD_REPEAT_EN to compile in auto-repeat of held keys (register key excluded).
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] digit,
  output logic       store_digit,
  output logic       is_reg,
  output logic       op_valid,
  output logic [2:0] op
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV) + 1;
  localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0]   DebMax    = DebW'(DEBOUNCE_CYCLES);

  if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scanner: invalid parameter values");
  end

  typedef enum logic [1:0] {StScan, StDebounce, StEmit, StHold} state_e;

  state_e            state_q, state_d;
  logic [3:0]        sync1_q, col_s_q;
  logic [3:0]        row_q, row_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [DebW-1:0]   cnt_q, cnt_d;
  logic [3:0]        pat_q, pat_d;
  logic [3:0]        code_q, code_d;
  logic [3:0]        digit_q, digit_d;
  logic [2:0]        op_q, op_d;
  logic              store_q, store_d;
  logic              reg_q, reg_d;
  logic              opv_q, opv_d;
  logic              emit;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RepW-1:0] RepMax = RepW'(REPEAT_CYCLES);
  logic [RepW-1:0] rep_q, rep_d;
`else
  // Single pulse per press: no repeat state exists in this build.
`endif

  function automatic logic [1:0] row_idx(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (r[i]) idx = 2'(i);
    return idx;
  endfunction

  // Lowest set column wins when several keys in a row are down.
  function automatic logic [1:0] low_col(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (c[i]) idx = 2'(i);
    return idx;
  endfunction

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    code_d  = code_q;
    digit_d = digit_q;
    op_d    = op_q;
    store_d = 1'b0;
    reg_d   = 1'b0;
    opv_d   = 1'b0;
    emit    = 1'b0;

    unique case (state_q)
      StScan: begin
        if (dwell_q >= DwellLast) begin
          dwell_d = '0;
          if (col_s_q != 4'b0000) begin
            pat_d   = col_s_q;
            code_d  = {row_idx(row_q), low_col(col_s_q)};
            cnt_d   = '0;
            state_d = StDebounce;
          end else begin
            row_d = {row_q[2:0], row_q[3]};
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      StDebounce: begin
        if (col_s_q != pat_q) begin
          state_d = StScan;
          row_d   = {row_q[2:0], row_q[3]};
          dwell_d = '0;
        end else if (cnt_q + 1'b1 >= DebMax) begin
          state_d = StEmit;
          emit    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEmit: begin
        state_d = StHold;
        cnt_d   = '0;
      end
      StHold: begin
        if (col_s_q != 4'b0000) begin
          cnt_d = '0;
        end else if (cnt_q + 1'b1 >= DebMax) begin
          state_d = StScan;
          row_d   = 4'b0001;
          dwell_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StScan;
    endcase

`ifdef KEYPAD_REPEAT_EN
    // Counts consecutive cycles the latched pattern is held, restarting at each pulse.
    rep_d = '0;
    if ((state_q == StEmit || state_q == StHold) && col_s_q == pat_q) begin
      if (state_q == StHold && code_q != 4'd10 && rep_q + 1'b1 >= RepMax) begin
        emit  = 1'b1;
        rep_d = '0;
      end else if (rep_q < RepMax) begin
        rep_d = rep_q + 1'b1;
      end else begin
        rep_d = rep_q;
      end
    end
`endif

    if (emit) begin
      if (code_q < 4'd10) begin
        store_d = 1'b1;
        digit_d = code_q;
      end else if (code_q == 4'd10) begin
        reg_d = 1'b1;
      end else begin
        opv_d = 1'b1;
        op_d  = 3'(code_q - 4'd11);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      col_s_q <= '0;
      state_q <= StScan;
      row_q   <= 4'b0001;
      dwell_q <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      code_q  <= '0;
      digit_q <= '0;
      op_q    <= '0;
      store_q <= 1'b0;
      reg_q   <= 1'b0;
      opv_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      sync1_q <= col_in;
      col_s_q <= sync1_q;
      state_q <= state_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      code_q  <= code_d;
      digit_q <= digit_d;
      op_q    <= op_d;
      store_q <= store_d;
      reg_q   <= reg_d;
      opv_q   <= opv_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign row_out     = row_q;
  assign digit       = digit_q;
  assign op          = op_q;
  assign store_digit = store_q;
  assign is_reg      = reg_q;
  assign op_valid    = opv_q;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// tb_keypad_scanner: keypad matrix stimulus, timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RP = 32;
  localparam int MS_SCAN = 0, MS_DEB = 1, MS_EMIT = 2, MS_HOLD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in, row_out, digit;
  logic       store_digit, is_reg, op_valid;
  logic [2:0] op;
  logic [15:0] keys = '0;

  int n_vec = 0;
  int n_err = 0;
  int n_sd = 0, n_reg = 0, n_opv = 0;

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_in     (col_in),
    .row_out    (row_out),
    .digit      (digit),
    .store_digit(store_digit),
    .is_reg     (is_reg),
    .op_valid   (op_valid),
    .op         (op)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key connects its row drive to its column sense.
  always_comb begin
    col_in = 4'b0000;
    for (int r = 0; r < 4; r++) if (row_out[r]) col_in = col_in | keys[r*4 +: 4];
  end

  // Reference model: timestamps of dwell/debounce/release/repeat starts instead of counters.
  int t = 0, m_st = MS_SCAN, m_row = 0, dwell_start = 0, deb_start = 0;
  int pat = 0, code = 0, last_nz = 0, match_start = 0, sy1 = 0, sy2 = 0, old_st = 0, cs = 0;
  bit fire = 0, model_valid = 0;
  logic [3:0] e_row = 4'b0001, e_digit = '0;
  logic [2:0] e_op = '0;
  logic       e_sd = 0, e_reg = 0, e_opv = 0;

  function automatic int lowcol(input int c);
    for (int i = 0; i < 4; i++) if (c[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    cs = sy2;
    fire = 0;
    e_sd = 0; e_reg = 0; e_opv = 0;
    if (rst) begin
      m_st = MS_SCAN; m_row = 0; dwell_start = t + 1;
      sy1 = 0; sy2 = 0; e_digit = '0; e_op = '0;
      model_valid = 1;
    end else begin
      old_st = m_st;
      case (m_st)
        MS_SCAN: if (t - dwell_start == SD - 1) begin
          if (cs != 0) begin
            pat = cs; code = m_row * 4 + lowcol(cs); m_st = MS_DEB; deb_start = t + 1;
          end else begin
            m_row = (m_row + 1) % 4; dwell_start = t + 1;
          end
        end
        MS_DEB: if (cs != pat) begin
          m_st = MS_SCAN; m_row = (m_row + 1) % 4; dwell_start = t + 1;
        end else if (t - deb_start + 1 == DB) begin
          m_st = MS_EMIT; fire = 1; match_start = t + 1;
        end
        MS_EMIT: begin
          m_st = MS_HOLD; last_nz = t;
        end
        default: if (cs != 0) last_nz = t;
          else if (t - last_nz == DB) begin
            m_st = MS_SCAN; m_row = 0; dwell_start = t + 1;
          end
      endcase
`ifdef KEYPAD_REPEAT_EN
      if (old_st == MS_EMIT || old_st == MS_HOLD) begin
        if (cs != pat) match_start = t + 1;
        else if (old_st == MS_HOLD && code != 10 && t - match_start + 1 == RP) begin
          fire = 1; match_start = t + 1;
        end
      end
`endif
      if (fire) begin
        if (code < 10) begin e_sd = 1; e_digit = 4'(code); end
        else if (code == 10) e_reg = 1;
        else begin e_opv = 1; e_op = 3'(code - 11); end
      end
      sy2 = sy1;
      sy1 = int'(col_in);
    end
    e_row = 4'(1 << m_row);
    t++;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      n_vec++;
      if ({row_out, digit, op, store_digit, is_reg, op_valid} !==
          {e_row, e_digit, e_op, e_sd, e_reg, e_opv}) begin
        n_err++;
        $display("FAIL model t=%0d got row=%b digit=%0d op=%0d sd/reg/opv=%b%b%b, need row=%b digit=%0d op=%0d sd/reg/opv=%b%b%b",
                 t, row_out, digit, op, store_digit, is_reg, op_valid,
                 e_row, e_digit, e_op, e_sd, e_reg, e_opv);
      end
    end
    if (store_digit === 1'b1) n_sd++;
    if (is_reg === 1'b1) n_reg++;
    if (op_valid === 1'b1) n_opv++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int got, input int need);
    n_vec++;
    if (got != need) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d", name, got, need);
    end
  endtask

  task automatic clr_counts();
    n_sd = 0; n_reg = 0; n_opv = 0;
  endtask

  int k, k2;

  initial begin
    // Reset and first row rotation
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("reset_row", int'(row_out), 1);
    chk("reset_pulses", int'({store_digit, is_reg, op_valid}), 0);
    chk("reset_digit_op", int'({digit, op}), 0);
    tick(4);
    chk("row_after_dwell", int'(row_out), 2);

    // Clean press of code 7
    clr_counts();
    keys[7] = 1'b1;
    tick(40);
    keys = '0;
    tick(20);
    chk("press7_count", n_sd, 1);
    chk("press7_digit", int'(digit), 7);
    chk("press7_others", n_reg + n_opv, 0);

    // Bounce on the register key then stable press
    clr_counts();
    keys[10] = 1'b1; tick(5);
    keys = '0;       tick(2);
    keys[10] = 1'b1; tick(40);
    keys = '0;       tick(20);
    chk("bounce_reg_count", n_reg, 1);
    chk("bounce_others", n_sd + n_opv, 0);

    // Two keys in row 3: lowest column (code 13) wins
    clr_counts();
    keys[13] = 1'b1; keys[14] = 1'b1;
    tick(40);
    keys = '0;
    tick(20);
    chk("multi_opv_count", n_opv, 1);
    chk("multi_op", int'(op), 2);
    chk("multi_others", n_sd + n_reg, 0);

    // Reset while debouncing
    clr_counts();
    rst = 1'b1; keys[0] = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0; keys = '0;
    chk("middeb_row", int'(row_out), 1);
    chk("middeb_digit_op", int'({digit, op}), 0);
    tick(20);
    chk("middeb_no_pulse", n_sd + n_reg + n_opv, 0);

    // Long hold of digit 3 and of the register key
    rst = 1'b1; tick(1); rst = 1'b0;
    clr_counts();
    keys[3] = 1'b1;
    tick(100);
    keys = '0;
    tick(20);
`ifdef KEYPAD_REPEAT_EN
    chk("hold3_count", n_sd, 3);
`else
    chk("hold3_count", n_sd, 1);
`endif
    chk("hold3_digit", int'(digit), 3);
    rst = 1'b1; tick(1); rst = 1'b0;
    clr_counts();
    keys[10] = 1'b1;
    tick(100);
    keys = '0;
    tick(20);
    chk("hold_reg_count", n_reg, 1);

    // Randomized presses, bounces, extra keys and resets
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        keys[k] = 1'b1; tick($urandom_range(1, DB - 1));
        keys = '0;      tick($urandom_range(1, 3));
      end
      keys[k] = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        k2 = $urandom_range(0, 15);
        keys[k2] = 1'b1;
      end
      tick($urandom_range(10, 120));
      if ($urandom_range(0, 3) == 0) begin
        keys = '0;      tick($urandom_range(1, DB - 1));
        keys[k] = 1'b1; tick($urandom_range(1, 5));
      end
      keys = '0;
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1; tick($urandom_range(1, 2)); rst = 1'b0;
      end
      tick($urandom_range(0, 30));
    end
    tick(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
